jtbubl_sndcomm: RTL and testbench
=================================

Name: jtbubl_sndcomm

Overview:
- Mailbox between the main Z80 and the sound Z80: command latch (main→sound), reply latch (sound→main), pending/overrun flags, sound NMI generation and a stretched sound-CPU reset.
- Main-side chip select is the 0xFA00–0xFA7F decode.
- Replaces the bare write-only latch with a full bidirectional handshake.
- Outputs feed the sound CPU wrapper directly.

Parameters:
- RST_MIN, 16: minimum snd_rst assertion length, counted in cen cycles.
- CMD_RST, 8'h00: command latch value after reset.

Ports:
- clk24 input 1: system clock.
- rst input 1: asynchronous reset, active high.
- cen input 1: clock enable; all sequential updates except the reset-stretch counter occur on clk24 edges regardless of cen.
- main_cs input 1: main sound-comm select, level, held across several clk24 cycles per access.
- main_wrn input 1: main write strobe, active low.
- main_addr input 2: main register offset (cpu_addr[1:0]).
- main_dout input 8: main write data.
- main_din output 8: read data to main CPU.
- snd_cs input 1: sound-side mailbox select, level.
- snd_wrn input 1: sound write strobe, active low.
- snd_addr input 2: sound register offset.
- snd_dout input 8: sound write data.
- snd_din output 8: read data to sound CPU.
- snd_nmi_n output 1: NMI to sound CPU, active low.
- snd_rst output 1: sound CPU reset, active high.
- cmd_pend output 1: command waiting (debug/status).

Behaviour:
- Clocking and reset: one clock clk24; reset rst is asynchronous, active high.
- Reset values: cmd latch = CMD_RST, reply = 8'h00, cmd_pend = 0, reply_pend = 0, cmd_ovf = 0, nmi_en = 0, snd_rst = 1, stretch counter = RST_MIN-1.
- Access events: one event per access, generated on the rising edge of main_cs or snd_cs (registered last_cs). Read/write decided by the wrn value sampled at that edge. Event takes effect on the next clk24 edge.
- Main writes:
  - off 0: cmd ← main_dout; cmd_pend ← 1; if cmd_pend was already 1, cmd_ovf ← 1.
  - off 3: rst_req ← main_dout[0].
  - off 1, 2: ignored.
- Main reads (main_din combinational, valid whenever main_cs = 1):
  - off 0: reply; the event clears reply_pend.
  - off 1: {5'b0, cmd_ovf, reply_pend, cmd_pend}; the event clears cmd_ovf.
  - off 2, 3: 8'hFF.
- Sound writes:
  - off 0: reply ← snd_dout; reply_pend ← 1.
  - off 1: nmi_en ← 1.
  - off 2: nmi_en ← 0.
  - off 3: ignored.
- Sound reads (snd_din combinational):
  - off 0: cmd; the event clears cmd_pend.
  - off 1: {6'b0, reply_pend, cmd_pend}.
  - others: 8'hFF.
- NMI: snd_nmi_n = ~(cmd_pend & nmi_en & ~snd_rst), registered with 1 clk24 latency.
- Reset stretch:
  - rst_req rising → counter reloads RST_MIN-1, snd_rst ← 1.
  - While rst_req = 1 → snd_rst stays 1.
  - After rst_req falls → counter decrements on cen; snd_rst ← 0 only when the counter reaches 0 and rst_req = 0. A pulse shorter than RST_MIN still gives RST_MIN cens.
- While snd_rst = 1: nmi_en forced 0; sound-side events ignored. cmd, cmd_pend and reply are preserved, so the main CPU may post a command before release.
- Simultaneous events on the same flag (set and clear in one cycle): set wins. E.g. main cmd write plus sound cmd read → cmd_pend = 1 and the new cmd is latched; the sound CPU sees the old value in the same cycle.
- main_cs held continuously generates no further events.
- rst asserted mid-access: all state returns to reset values. last_cs resets to 0, so a cs still high after rst release produces one event.

Optional Feature:
- JTBUBL_SNDCOMM_FIFO_EN defined: the command path is a 4-entry FIFO.
  - Main off-0 write pushes; sound off-0 read pops.
  - cmd_pend = not empty.
  - cmd_ovf set on a push while full; that push is dropped.
  - Read of an empty FIFO returns the last popped value.
  - FIFO is flushed by rst only.
- Undefined: single latch exactly as above.

Test Plan:
- Reset → main_din at off 1 = 8'h00, snd_rst = 1 for RST_MIN cens after rst_req = 0, snd_nmi_n = 1.
- Main write 0x5A at off 0, sound writes off 1 → snd_nmi_n low 1 clk later; sound read off 0 returns 0x5A, then snd_nmi_n returns high, cmd_pend = 0.
- Two main writes 0x11, 0x22 with no sound read → off-1 read = 8'h05 (ovf, pend), next off-1 read = 8'h01; sound reads 0x22. With FIFO_EN: reads 0x11 then 0x22, no ovf.
- Sound write reply 0xC3 → main off-1 bit1 = 1; main off-0 read = 0xC3, then bit1 = 0.
- Main write off 3 with 1 then 0 within 2 cens → snd_rst high exactly RST_MIN cens after the 0; nmi_en = 0 afterwards; a pending cmd survives.
- main_cs held 10 clks with one write, and a cmd write coinciding with a sound cmd read → exactly one event; cmd_pend = 1.

Source files
------------

// File: rtl/jtbubl_sndcomm.sv
// Main/sound CPU mailbox: command and reply latches, status flags,
// sound NMI and stretched sound reset. Option: JTBUBL_SNDCOMM_FIFO_EN.
module jtbubl_sndcomm #(
  parameter int          RST_MIN = 16,
  parameter logic [7:0]  CMD_RST = 8'h00
) (
  input  logic       clk24,
  input  logic       rst,
  input  logic       cen,
  input  logic       main_cs,
  input  logic       main_wrn,
  input  logic [1:0] main_addr,
  input  logic [7:0] main_dout,
  output logic [7:0] main_din,
  input  logic       snd_cs,
  input  logic       snd_wrn,
  input  logic [1:0] snd_addr,
  input  logic [7:0] snd_dout,
  output logic [7:0] snd_din,
  output logic       snd_nmi_n,
  output logic       snd_rst,
  output logic       cmd_pend
);

  localparam int CW = $clog2(RST_MIN + 1);

  logic          main_last;
  logic          snd_last;
  logic          main_ev;
  logic          snd_ev;
  logic          m_wr;
  logic          m_rd;
  logic          s_wr;
  logic          s_rd;
  logic          m_cmd_wr;
  logic          m_rst_wr;
  logic          m_reply_rd;
  logic          m_stat_rd;
  logic          s_reply_wr;
  logic          s_nmi_on;
  logic          s_nmi_off;
  logic          s_cmd_rd;
  logic          push_ovf;
  logic [7:0]    cmd_q;
  logic [7:0]    reply;
  logic          reply_pend;
  logic          cmd_ovf;
  logic          nmi_en;
  logic          rst_req;
  logic [CW-1:0] cnt;

  // One event per rising edge of a select; sound side is deaf in reset
  assign main_ev    = main_cs & ~main_last;
  assign snd_ev     = snd_cs & ~snd_last & ~snd_rst;
  assign m_wr       = main_ev & ~main_wrn;
  assign m_rd       = main_ev & main_wrn;
  assign s_wr       = snd_ev & ~snd_wrn;
  assign s_rd       = snd_ev & snd_wrn;
  assign m_cmd_wr   = m_wr & (main_addr == 2'd0);
  assign m_rst_wr   = m_wr & (main_addr == 2'd3);
  assign m_reply_rd = m_rd & (main_addr == 2'd0);
  assign m_stat_rd  = m_rd & (main_addr == 2'd1);
  assign s_reply_wr = s_wr & (snd_addr == 2'd0);
  assign s_nmi_on   = s_wr & (snd_addr == 2'd1);
  assign s_nmi_off  = s_wr & (snd_addr == 2'd2);
  assign s_cmd_rd   = s_rd & (snd_addr == 2'd0);

  // Select edge detectors
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      main_last <= 1'b0;
      snd_last  <= 1'b0;
    end else begin
      main_last <= main_cs;
      snd_last  <= snd_cs;
    end
  end

`ifdef JTBUBL_SNDCOMM_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] used;
  logic [7:0] last;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  assign full     = (used == 3'd4);
  assign empty    = (used == 3'd0);
  assign push     = m_cmd_wr & ~full;
  assign pop      = s_cmd_rd & ~empty;
  assign push_ovf = m_cmd_wr & full;
  assign cmd_pend = ~empty;
  assign cmd_q    = empty ? last : mem[rp];

  // Command FIFO; an empty read repeats the last popped byte
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= CMD_RST;
      wp   <= 2'd0;
      rp   <= 2'd0;
      used <= 3'd0;
      last <= CMD_RST;
    end else begin
      if (push) begin
        mem[wp] <= main_dout;
        wp      <= wp + 2'd1;
      end
      if (pop) begin
        last <= mem[rp];
        rp   <= rp + 2'd1;
      end
      used <= used + 3'(push) - 3'(pop);
    end
  end
`else
  logic [7:0] cmd;

  assign push_ovf = m_cmd_wr & cmd_pend;
  assign cmd_q    = cmd;

  // Single command latch; a new write beats a same-cycle read
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      cmd      <= CMD_RST;
      cmd_pend <= 1'b0;
    end else begin
      if (m_cmd_wr) cmd <= main_dout;
      if (m_cmd_wr)      cmd_pend <= 1'b1;
      else if (s_cmd_rd) cmd_pend <= 1'b0;
    end
  end
`endif

  // Reply latch, flags and NMI enable
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      reply      <= 8'h00;
      reply_pend <= 1'b0;
      cmd_ovf    <= 1'b0;
      nmi_en     <= 1'b0;
      rst_req    <= 1'b0;
    end else begin
      if (s_reply_wr) reply <= snd_dout;
      if (s_reply_wr)      reply_pend <= 1'b1;
      else if (m_reply_rd) reply_pend <= 1'b0;
      if (push_ovf)       cmd_ovf <= 1'b1;
      else if (m_stat_rd) cmd_ovf <= 1'b0;
      if (snd_rst)        nmi_en <= 1'b0;
      else if (s_nmi_on)  nmi_en <= 1'b1;
      else if (s_nmi_off) nmi_en <= 1'b0;
      if (m_rst_wr) rst_req <= main_dout[0];
    end
  end

  // Sound reset held while requested, then RST_MIN more cens
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      cnt     <= CW'(RST_MIN - 1);
      snd_rst <= 1'b1;
    end else if (rst_req) begin
      cnt     <= CW'(RST_MIN - 1);
      snd_rst <= 1'b1;
    end else if (snd_rst && cen) begin
      if (cnt == '0) snd_rst <= 1'b0;
      else           cnt     <= cnt - CW'(1);
    end
  end

  // Registered NMI request
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) snd_nmi_n <= 1'b1;
    else     snd_nmi_n <= ~(cmd_pend & nmi_en & ~snd_rst);
  end

  // Main read mux
  always_comb begin
    main_din = 8'hFF;
    case (main_addr)
      2'd0:    main_din = reply;
      2'd1:    main_din = {5'b0, cmd_ovf, reply_pend, cmd_pend};
      default: main_din = 8'hFF;
    endcase
  end

  // Sound read mux
  always_comb begin
    snd_din = 8'hFF;
    case (snd_addr)
      2'd0:    snd_din = cmd_q;
      2'd1:    snd_din = {6'b0, reply_pend, cmd_pend};
      default: snd_din = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Self-checking bench for jtbubl_sndcomm: vector table, hand
// sequences for reset/stretch/concurrency, randomized model compare.
module tb_jtbubl_sndcomm;

  localparam int RST_MIN = 16;
`ifdef JTBUBL_SNDCOMM_FIFO_EN
  localparam logic [7:0] OVF_STAT  = 8'h01;
  localparam logic [7:0] FIRST_POP = 8'h11;
  localparam logic       NMI_R10   = 1'b0;
  localparam logic [7:0] COINC_ST  = 8'h01;
`else
  localparam logic [7:0] OVF_STAT  = 8'h05;
  localparam logic [7:0] FIRST_POP = 8'h22;
  localparam logic       NMI_R10   = 1'b1;
  localparam logic [7:0] COINC_ST  = 8'h05;
`endif

  logic       clk24 = 1'b0;
  logic       rst;
  logic       cen;
  logic       main_cs;
  logic       main_wrn;
  logic [1:0] main_addr;
  logic [7:0] main_dout;
  logic [7:0] main_din;
  logic       snd_cs;
  logic       snd_wrn;
  logic [1:0] snd_addr;
  logic [7:0] snd_dout;
  logic [7:0] snd_din;
  logic       snd_nmi_n;
  logic       snd_rst;
  logic       cmd_pend;

  int checks = 0;
  int failures = 0;

  jtbubl_sndcomm dut (
    .clk24(clk24), .rst(rst), .cen(cen),
    .main_cs(main_cs), .main_wrn(main_wrn),
    .main_addr(main_addr), .main_dout(main_dout),
    .main_din(main_din),
    .snd_cs(snd_cs), .snd_wrn(snd_wrn),
    .snd_addr(snd_addr), .snd_dout(snd_dout),
    .snd_din(snd_din),
    .snd_nmi_n(snd_nmi_n), .snd_rst(snd_rst),
    .cmd_pend(cmd_pend)
  );

  initial forever #5 clk24 = ~clk24;

  initial begin
    cen = 1'b0;
    forever begin
      @(negedge clk24);
      cen = ~cen;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One access: select rises at a negedge, event on the next posedge
  task automatic acc(input bit snd, input bit wr, input logic [1:0] a,
                     input logic [7:0] d, input int hold,
                     output logic [7:0] rd);
    @(negedge clk24);
    if (snd) begin
      snd_cs = 1'b1; snd_wrn = ~wr; snd_addr = a; snd_dout = d;
    end else begin
      main_cs = 1'b1; main_wrn = ~wr; main_addr = a; main_dout = d;
    end
    #1 rd = snd ? snd_din : main_din;
    @(posedge clk24);
    repeat (hold) @(posedge clk24);
    @(negedge clk24);
    main_cs = 1'b0; main_wrn = 1'b1;
    snd_cs  = 1'b0; snd_wrn  = 1'b1;
    @(negedge clk24);
  endtask

  // Counts cen edges until snd_rst drops (bounded)
  task automatic count_stretch(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk24);
      #1;
      if (cen) n++;
      if (!snd_rst) break;
    end
    if (snd_rst) n = -1;
  endtask

  // Mailbox-level reference model
  logic [7:0] m_cmd;
  bit         m_pend;
  logic [7:0] mq[$];
  logic [7:0] m_last;
  logic [7:0] m_reply;
  bit         m_rpend;
  bit         m_ovf;
  bit         m_nmi_en;

  function automatic bit mpend();
`ifdef JTBUBL_SNDCOMM_FIFO_EN
    return mq.size() != 0;
`else
    return m_pend;
`endif
  endfunction

  task automatic model_reset();
    m_cmd = 8'h00; m_pend = 0; mq.delete(); m_last = 8'h00;
    m_reply = 8'h00; m_rpend = 0; m_ovf = 0; m_nmi_en = 0;
  endtask

  task automatic model_push(input logic [7:0] d);
`ifdef JTBUBL_SNDCOMM_FIFO_EN
    if (mq.size() == 4) m_ovf = 1;
    else mq.push_back(d);
`else
    if (m_pend) m_ovf = 1;
    m_cmd = d;
    m_pend = 1;
`endif
  endtask

  task automatic model_pop(output logic [7:0] v);
`ifdef JTBUBL_SNDCOMM_FIFO_EN
    if (mq.size() != 0) begin
      v = mq.pop_front();
      m_last = v;
    end else v = m_last;
`else
    v = m_cmd;
    m_pend = 0;
`endif
  endtask

  typedef struct packed {
    logic       snd;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] d;
    logic [7:0] exp;
    logic       nmi;
  } vec_t;

  vec_t tbl[18];

  logic [7:0] r;
  logic [7:0] e;
  int         n;
  bit         rs;
  bit         rw;
  logic [1:0] ra;
  logic [7:0] rdat;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 8'h5A, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h5A, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 8'h11, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 8'h22, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd1, 8'h00, OVF_STAT, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd1, 8'h00, 8'h01, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'h00, FIRST_POP, NMI_R10};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h22, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 2'd0, 8'hC3, 8'h00, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 2'd1, 8'h00, 8'h02, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 8'h00, 8'hC3, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 2'd2, 8'h00, 8'hFF, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'hFF, 1'b1};

    rst = 1'b1;
    main_cs = 1'b0; main_wrn = 1'b1; main_addr = 2'd0; main_dout = 8'h00;
    snd_cs  = 1'b0; snd_wrn  = 1'b1; snd_addr  = 2'd0; snd_dout  = 8'h00;
    repeat (3) @(negedge clk24);
    chk("por_snd_rst", {7'b0, snd_rst}, 8'h01);
    chk("por_nmi_n", {7'b0, snd_nmi_n}, 8'h01);
    chk("por_cmd_pend", {7'b0, cmd_pend}, 8'h00);
    rst = 1'b0;
    count_stretch(n);
    chk_int("por_stretch_cens", n, RST_MIN);

    for (int i = 0; i < 18; i++) begin
      acc(tbl[i].snd, tbl[i].wr, tbl[i].addr, tbl[i].d, 0, r);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_rd", i), r, tbl[i].exp);
      chk($sformatf("tbl%0d_nmi", i), {7'b0, snd_nmi_n},
          {7'b0, tbl[i].nmi});
    end

    acc(0, 1, 2'd0, 8'h77, 10, r);
    acc(0, 0, 2'd1, 8'h00, 0, r);
    chk("held_cs_stat", r, 8'h01);
    acc(1, 0, 2'd0, 8'h00, 0, r);
    chk("held_cs_cmd", r, 8'h77);

    acc(0, 1, 2'd0, 8'h66, 0, r);
    @(negedge clk24);
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = 2'd0; main_dout = 8'h88;
    snd_cs  = 1'b1; snd_wrn  = 1'b1; snd_addr  = 2'd0;
    #1 r = snd_din;
    @(posedge clk24);
    @(negedge clk24);
    main_cs = 1'b0; main_wrn = 1'b1; snd_cs = 1'b0;
    @(negedge clk24);
    chk("coinc_old_cmd", r, 8'h66);
    chk("coinc_pend", {7'b0, cmd_pend}, 8'h01);
    acc(0, 0, 2'd1, 8'h00, 0, r);
    chk("coinc_stat", r, COINC_ST);
    acc(1, 0, 2'd0, 8'h00, 0, r);
    chk("coinc_new_cmd", r, 8'h88);

    acc(0, 1, 2'd0, 8'hAB, 0, r);
    chk("pre_rst_nmi", {7'b0, snd_nmi_n}, 8'h00);
    acc(0, 1, 2'd3, 8'h01, 0, r);
    acc(1, 1, 2'd0, 8'h5E, 0, r);
    @(negedge clk24);
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = 2'd3; main_dout = 8'h00;
    @(posedge clk24);
    #1 main_cs = 1'b0; main_wrn = 1'b1;
    count_stretch(n);
    chk_int("req_stretch_cens", n, RST_MIN);
    @(negedge clk24);
    chk("post_rst_nmi", {7'b0, snd_nmi_n}, 8'h01);
    chk("post_rst_pend", {7'b0, cmd_pend}, 8'h01);
    acc(0, 0, 2'd1, 8'h00, 0, r);
    chk("post_rst_stat", r, 8'h01);
    acc(1, 0, 2'd0, 8'h00, 0, r);
    chk("post_rst_cmd", r, 8'hAB);

    @(negedge clk24);
    main_cs = 1'b1; main_wrn = 1'b0; main_addr = 2'd0; main_dout = 8'h99;
    rst = 1'b1;
    repeat (3) @(negedge clk24);
    rst = 1'b0;
    repeat (4) @(negedge clk24);
    main_cs = 1'b0; main_wrn = 1'b1;
    @(negedge clk24);
    chk("midrst_snd_rst", {7'b0, snd_rst}, 8'h01);
    acc(0, 0, 2'd1, 8'h00, 0, r);
    chk("midrst_stat", r, 8'h01);
    count_stretch(n);
    chk("midrst_release", {7'b0, snd_rst}, 8'h00);
    acc(1, 0, 2'd0, 8'h00, 0, r);
    chk("midrst_cmd", r, 8'h99);

    model_reset();
    m_cmd = 8'h99;
    m_last = 8'h99;
    for (int i = 0; i < 300; i++) begin
      rs = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      ra = 2'($urandom_range(0, 3));
      rdat = 8'($urandom);
      if (!rs && rw && ra == 2'd3) ra = 2'd1;
      e = 8'hFF;
      if (!rs) begin
        if (rw) begin
          if (ra == 2'd0) model_push(rdat);
        end else begin
          case (ra)
            2'd0: begin e = m_reply; m_rpend = 0; end
            2'd1: begin
              e = {5'b0, m_ovf, m_rpend, mpend()};
              m_ovf = 0;
            end
            default: e = 8'hFF;
          endcase
        end
      end else begin
        if (rw) begin
          case (ra)
            2'd0: begin m_reply = rdat; m_rpend = 1; end
            2'd1: m_nmi_en = 1;
            2'd2: m_nmi_en = 0;
            default: ;
          endcase
        end else begin
          case (ra)
            2'd0: model_pop(e);
            2'd1: e = {6'b0, m_rpend, mpend()};
            default: e = 8'hFF;
          endcase
        end
      end
      acc(rs, rw, ra, rdat, $urandom_range(0, 2), r);
      if (!rw) chk($sformatf("rand%0d_rd", i), r, e);
      chk($sformatf("rand%0d_nmi", i), {7'b0, snd_nmi_n},
          {7'b0, ~(mpend() & m_nmi_en)});
      chk($sformatf("rand%0d_pend", i), {7'b0, cmd_pend},
          {7'b0, mpend()});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
